// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry sequencer: phase encoding and
// state-index helpers that depend on the operand count.
package calc_pkg;

  // Coarse FSM phase; the operand slot within PH_LOAD is tracked separately.
  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_OP   = 2'd1,
    PH_DONE = 2'd2
  } phase_e;

  // Width of the exported state index (LOAD_0..LOAD_N-1, LOAD_OP, DONE).
  function automatic int state_w(input int num_operands);
    return $clog2(num_operands + 2);
  endfunction

  // State index of the operator-load step.
  function automatic int load_op_idx(input int num_operands);
    return num_operands;
  endfunction

  // State index of the terminal DONE step.
  function automatic int done_idx(input int num_operands);
    return num_operands + 1;
  endfunction

endpackage

// File: rtl/calc_idle_timer.sv
// Idle watchdog: counts cycles spent mid-entry and flags expiry so the
// sequencer can abandon a stale partial entry. Disabled when IDLE_TIMEOUT = 0.
module calc_idle_timer #(
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);

  generate
    if (IDLE_TIMEOUT == 0) begin : g_off
      // No counter at all; inputs are intentionally left unused.
      logic unused_ok;
      assign unused_ok = ^{clk, reset, run, kick};
      assign expire    = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(IDLE_TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // Count idle cycles while running; any edge or leaving the run window
      // reloads zero, and the count saturates at LAST so it never wraps.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (kick || !run)      cnt <= '0;
        else if (cnt != LAST)       cnt <= cnt + CW'(1);
      end

      // An edge in the expiry cycle wins, so kick masks the expiry flag.
      assign expire = run && !kick && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/calc_sequencer.sv
// Calculator entry sequencer: walks operand slots, then the operator, then
// DONE, driven by right (advance) and left (back/clear) edge pulses. All
// outputs are registered; strobes last exactly one cycle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter  int NUM_OPERANDS = 2,
  parameter  int IDLE_TIMEOUT = 0,
  localparam int STATE_W      = state_w(NUM_OPERANDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_edge_r,
  input  logic                    btn_edge_l,
  output logic [NUM_OPERANDS-1:0] load_operand,
  output logic                    load_op,
  output logic                    done,
  output logic                    clear,
  output logic [STATE_W-1:0]      state_debug
);

  localparam int LOAD_OP_IDX = load_op_idx(NUM_OPERANDS);
  localparam int DONE_IDX    = done_idx(NUM_OPERANDS);

  localparam logic [STATE_W-1:0] LAST_K = STATE_W'(NUM_OPERANDS - 1);
  localparam logic [STATE_W-1:0] OP_SD  = STATE_W'(LOAD_OP_IDX);
  localparam logic [STATE_W-1:0] DN_SD  = STATE_W'(DONE_IDX);

  phase_e             phase;
  logic [STATE_W-1:0] idx;     // operand slot while in PH_LOAD
  logic               run;
  logic               kick;
  logic               expire;

  // Idle time only accrues mid-entry: not in LOAD_0 and not in DONE.
  assign run  = (phase == PH_LOAD) ? (idx != '0) : (phase == PH_OP);
  assign kick = btn_edge_r | btn_edge_l;

  calc_idle_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_idle (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .kick   (kick),
    .expire (expire)
  );

  // Sequencer FSM with registered strobes; left edge beats right edge, and
  // either edge beats the idle expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase        <= PH_LOAD;
      idx          <= '0;
      load_operand <= '0;
      load_op      <= 1'b0;
      done         <= 1'b0;
      clear        <= 1'b0;
      state_debug  <= '0;
    end else begin
      load_operand <= '0;
      load_op      <= 1'b0;
      clear        <= 1'b0;
      unique case (phase)
        PH_LOAD: begin
          if (btn_edge_l) begin
            if (idx != '0) begin
              idx         <= idx - STATE_W'(1);
              state_debug <= idx - STATE_W'(1);
            end
          end else if (btn_edge_r) begin
            load_operand <= NUM_OPERANDS'(1) << idx;
            if (idx == LAST_K) begin
              phase       <= PH_OP;
              state_debug <= OP_SD;
            end else begin
              idx         <= idx + STATE_W'(1);
              state_debug <= idx + STATE_W'(1);
            end
          end else if (expire) begin
            idx         <= '0;
            clear       <= 1'b1;
            state_debug <= '0;
          end
        end
        PH_OP: begin
          if (btn_edge_l) begin
            phase       <= PH_LOAD;
            idx         <= LAST_K;
            state_debug <= LAST_K;
          end else if (btn_edge_r) begin
            phase       <= PH_DONE;
            load_op     <= 1'b1;
            done        <= 1'b1;
            state_debug <= DN_SD;
          end else if (expire) begin
            phase       <= PH_LOAD;
            idx         <= '0;
            clear       <= 1'b1;
            state_debug <= '0;
          end
        end
        PH_DONE: begin
          // Right edge is ignored here; only left leaves DONE.
          if (btn_edge_l) begin
            phase       <= PH_LOAD;
            idx         <= '0;
            done        <= 1'b0;
            clear       <= 1'b1;
            state_debug <= '0;
          end
        end
        default: begin
          phase       <= PH_LOAD;
          idx         <= '0;
          done        <= 1'b0;
          state_debug <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: three instances (N=2/no timeout,
// N=4/no timeout, N=2/timeout 8) exercised by a linear step sequence.
module tb_calc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: N=2, no timeout
  logic       a_rst, a_r, a_l;
  logic [1:0] a_lo;
  logic       a_lop, a_done, a_clr;
  logic [1:0] a_sd;

  // Instance B: N=4, no timeout
  logic       b_r, b_l;
  logic [3:0] b_lo;
  logic       b_lop, b_done, b_clr;
  logic [2:0] b_sd;

  // Instance C: N=2, timeout 8
  logic       c_r, c_l;
  logic [1:0] c_lo;
  logic       c_lop, c_done, c_clr;
  logic [1:0] c_sd;

  logic bc_rst;

  calc_sequencer #(.NUM_OPERANDS(2), .IDLE_TIMEOUT(0)) dut_a (
    .clk(clk), .reset(a_rst), .btn_edge_r(a_r), .btn_edge_l(a_l),
    .load_operand(a_lo), .load_op(a_lop), .done(a_done), .clear(a_clr),
    .state_debug(a_sd));

  calc_sequencer #(.NUM_OPERANDS(4), .IDLE_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(bc_rst), .btn_edge_r(b_r), .btn_edge_l(b_l),
    .load_operand(b_lo), .load_op(b_lop), .done(b_done), .clear(b_clr),
    .state_debug(b_sd));

  calc_sequencer #(.NUM_OPERANDS(2), .IDLE_TIMEOUT(8)) dut_c (
    .clk(clk), .reset(bc_rst), .btn_edge_r(c_r), .btn_edge_l(c_l),
    .load_operand(c_lo), .load_op(c_lop), .done(c_done), .clear(c_clr),
    .state_debug(c_sd));

  // Output bundles: {load_operand, load_op, done, clear, state_debug}
  wire [6:0] a_v = {a_lo, a_lop, a_done, a_clr, a_sd};
  wire [9:0] b_v = {b_lo, b_lop, b_done, b_clr, b_sd};
  wire [6:0] c_v = {c_lo, c_lop, c_done, c_clr, c_sd};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b0; bc_rst = 1'b0;
    a_r = 0; a_l = 0; b_r = 0; b_l = 0; c_r = 0; c_l = 0;

    // Reset state
    #3;
    chk("a_reset", 16'(a_v), 16'(7'b00_0_0_0_00));
    chk("b_reset", 16'(b_v), 16'(10'b0000_0_0_0_000));
    chk("c_reset", 16'(c_v), 16'(7'b00_0_0_0_00));
    a_r = 1'b1;
    step(); step();
    chk("a_reset_held", 16'(a_v), 16'(7'b00_0_0_0_00));

    // Release with r already pending: honoured on the first edge
    a_rst = 1'b1; bc_rst = 1'b1;
    step(); chk("a_r1_op0",   16'(a_v), 16'(7'b01_0_0_0_01));
    step(); chk("a_r2_op1",   16'(a_v), 16'(7'b10_0_0_0_10));
    step(); chk("a_r3_op",    16'(a_v), 16'(7'b00_1_1_0_11));
    step(); chk("a_r_done",   16'(a_v), 16'(7'b00_0_1_0_11));
    a_r = 0; a_l = 1;
    step(); chk("a_l_clear",  16'(a_v), 16'(7'b00_0_0_1_00));
    a_l = 0;
    step(); chk("a_clear_1c", 16'(a_v), 16'(7'b00_0_0_0_00));

    // Simultaneous l and r in LOAD_1: l wins
    a_r = 1;
    step(); chk("a_lr_pre",   16'(a_v), 16'(7'b01_0_0_0_01));
    a_l = 1;
    step(); chk("a_lr_both",  16'(a_v), 16'(7'b00_0_0_0_00));
    a_r = 0; a_l = 0;

    // Async reset while in LOAD_OP
    a_r = 1;
    step(); step(); chk("a_to_op", 16'(a_v), 16'(7'b10_0_0_0_10));
    a_r = 0;
    step(); chk("a_in_op",    16'(a_v), 16'(7'b00_0_0_0_10));
    #2 a_rst = 1'b0;
    #1 chk("a_async_rst", 16'(a_v), 16'(7'b00_0_0_0_00));
    step(); a_rst = 1'b1;
    step(); chk("a_post_rst1", 16'(a_v), 16'(7'b00_0_0_0_00));
    step(); chk("a_post_rst2", 16'(a_v), 16'(7'b00_0_0_0_00));
    a_r = 1;
    step(); chk("a_post_rst_r", 16'(a_v), 16'(7'b01_0_0_0_01));
    a_r = 0;

    // N=4: r,r,l,r then through the operator and back out
    b_r = 1;
    step(); chk("b_r_op0",  16'(b_v), 16'(10'b0001_0_0_0_001));
    step(); chk("b_r_op1",  16'(b_v), 16'(10'b0010_0_0_0_010));
    b_r = 0; b_l = 1;
    step(); chk("b_l_back", 16'(b_v), 16'(10'b0000_0_0_0_001));
    b_l = 0; b_r = 1;
    step(); chk("b_r_again", 16'(b_v), 16'(10'b0010_0_0_0_010));
    step(); chk("b_r_op2",  16'(b_v), 16'(10'b0100_0_0_0_011));
    step(); chk("b_r_op3",  16'(b_v), 16'(10'b1000_0_0_0_100));
    b_r = 0; b_l = 1;
    step(); chk("b_l_from_op", 16'(b_v), 16'(10'b0000_0_0_0_011));
    b_l = 0; b_r = 1;
    step(); chk("b_r_op3b", 16'(b_v), 16'(10'b1000_0_0_0_100));
    step(); chk("b_r_opr",  16'(b_v), 16'(10'b0000_1_1_0_101));
    b_r = 0; b_l = 1;
    step(); chk("b_l_clear", 16'(b_v), 16'(10'b0000_0_0_1_000));
    step(); chk("b_l_load0", 16'(b_v), 16'(10'b0000_0_0_0_000));
    b_l = 0;

    // Timeout 8: r then 8 idle cycles -> clear
    c_r = 1;
    step(); chk("c_r_op0",  16'(c_v), 16'(7'b01_0_0_0_01));
    c_r = 0;
    repeat (7) step();
    chk("c_idle7",  16'(c_v), 16'(7'b00_0_0_0_01));
    step(); chk("c_timeout", 16'(c_v), 16'(7'b00_0_0_1_00));
    step(); chk("c_timeout_1c", 16'(c_v), 16'(7'b00_0_0_0_00));

    // Same, but r arrives in the expiry cycle: edge wins
    c_r = 1;
    step(); chk("c_r_op0b", 16'(c_v), 16'(7'b01_0_0_0_01));
    c_r = 0;
    repeat (7) step();
    c_r = 1;
    step(); chk("c_r_at_expiry", 16'(c_v), 16'(7'b10_0_0_0_10));
    c_r = 0;
    step(); chk("c_no_clear", 16'(c_v), 16'(7'b00_0_0_0_10));
    repeat (6) step();
    chk("c_op_idle7", 16'(c_v), 16'(7'b00_0_0_0_10));
    step(); chk("c_op_timeout", 16'(c_v), 16'(7'b00_0_0_1_00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_OPERANDS, default 2, number of operands loaded before the operator (legal 2..8).
REQ-002 The block SHALL have parameter IDLE_TIMEOUT, default 0, idle cycles before abandoning a partial entry (0 = timeout disabled).
REQ-003 The block SHALL have derived constant STATE_W = $clog2(NUM_OPERANDS+2), the state index width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port btn_edge_r, input, 1 bit, one-cycle "advance/enter" pulse from the edge detector.
REQ-007 The block SHALL have port btn_edge_l, input, 1 bit, one-cycle "back/clear" pulse from the edge detector.
REQ-008 The block SHALL have port load_operand, output, NUM_OPERANDS bits, one-hot one-cycle strobe; bit k loads operand k.
REQ-009 The block SHALL have port load_op, output, 1 bit, one-cycle strobe that loads the operator.
REQ-010 The block SHALL have port done, output, 1 bit, level, high while in DONE.
REQ-011 The block SHALL have port clear, output, 1 bit, one-cycle strobe telling the datapath to discard all registers.
REQ-012 The block SHALL have port state_debug, output, STATE_W bits, current state index.

Function
REQ-013 State index encoding SHALL be: 0..NUM_OPERANDS-1 = LOAD_k; NUM_OPERANDS = LOAD_OP; NUM_OPERANDS+1 = DONE.
REQ-014 All outputs SHALL be registered, with each strobe asserted in the cycle after the sampled edge pulse and lasting exactly one cycle.
REQ-015 In LOAD_k, btn_edge_r SHALL pulse load_operand[k] and move to LOAD_k+1 (LOAD_OP from k = NUM_OPERANDS-1).
REQ-016 In LOAD_OP, btn_edge_r SHALL pulse load_op and move to DONE; done rises in the same cycle as the load_op pulse.
REQ-017 In DONE, btn_edge_r SHALL be ignored: no strobe, no state change.
REQ-018 In LOAD_k with k>0, btn_edge_l SHALL step back to LOAD_k-1 with no strobe, and operand k-1 is then re-entered.
REQ-019 In LOAD_0, btn_edge_l SHALL be a no-op.
REQ-020 In LOAD_OP, btn_edge_l SHALL step back to LOAD_(NUM_OPERANDS-1).
REQ-021 In DONE, btn_edge_l SHALL move to LOAD_0 and pulse clear; done falls in the same cycle.
REQ-022 When btn_edge_l and btn_edge_r arrive in the same cycle, btn_edge_l SHALL win and btn_edge_r SHALL be discarded.
REQ-023 The idle counter SHALL count cycles while the state is neither LOAD_0 nor DONE, and any btn_edge_l/r SHALL reload it to zero.
REQ-024 When the count reaches IDLE_TIMEOUT-1 with no edge, the block SHALL move to LOAD_0 and pulse clear next cycle; an edge in the expiry cycle SHALL take priority over the timeout.
REQ-025 When IDLE_TIMEOUT = 0, the counter SHALL be absent or held at zero, and no timeout SHALL ever fire.
REQ-026 Counter width SHALL be $clog2(IDLE_TIMEOUT+1) and the counter SHALL never wrap.
REQ-027 At most one of load_operand/load_op/clear SHALL be high in any cycle.

Reset
REQ-028 While reset=0, the state SHALL be LOAD_0, the counter 0, and load_operand, load_op, done, clear and state_debug all 0.
REQ-029 A reset asserted mid-entry SHALL abort immediately with no strobe, and the block SHALL not pulse clear on reset release.
REQ-030 The first edge pulse SHALL be honoured in the first rising edge after reset deasserts.

Structure
REQ-031 The package calc_pkg SHALL hold the state index localparams (LOAD_OP_IDX, DONE_IDX as functions of NUM_OPERANDS) and the STATE_W computation.
REQ-032 The idle counter SHALL be a sub-module, calc_idle_timer (params IDLE_TIMEOUT; ports clk, reset, run, kick, expire).
REQ-033 The FSM and the strobe registers SHALL live in calc_sequencer.

Verification
REQ-034 With N=2 and timeout 0, after reset release, pulse r x3 -> load_operand=01, then 10, then load_op, each one cycle apart; done=1 and state_debug=3.
REQ-035 Continuing from DONE, pulse l -> clear pulses once, done=0, state_debug=0, and a further r still in DONE beforehand -> no strobe.
REQ-036 With N=4, enter r,r,l,r -> strobes operand0, operand1, none, operand1 again; state_debug sequence 1,2,1,2.
REQ-037 With N=2, l and r asserted in the same cycle in LOAD_1 -> state_debug=0 and no strobe.
REQ-038 With N=2 and IDLE_TIMEOUT=8, r then 8 idle cycles -> clear pulse and state_debug=0; the same case with r at idle cycle 7 -> no clear and state_debug=2.
REQ-039 Reset driven low in LOAD_OP -> all outputs 0 asynchronously, and 0 strobes after release.
